milspi_txn_ctrl: RTL and testbench

Transaction controller for the MIL-STD-1553 <-> SPI bridge. Decodes addressed SPI commands and sequences the two ring buffers' transaction controls: open/commit/rollback on the spi->mil buffer (SM) and the mil->spi buffer (MS). Also drives the SPI-side datapath selects: push gate, pop mux key, output enable and status enable. Sits between the SPI link's packet-event outputs and the ring buffer control ports, replacing static per-command configuration with a stateful, rollback-safe sequencer.

---
 rtl/milspi_txn_ctrl.sv | 173 +++++++++++++++++
 tb/tb_milspi_txn_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/milspi_txn_ctrl.sv
// Transaction sequencer for the MIL-STD-1553 <-> SPI bridge: decodes addressed SPI commands
// into ring-buffer open/commit/rollback pulses and SPI datapath selects. Watchdog: MILSPI_TXN_TIMEOUT_EN.
module milspi_txn_ctrl #(
    parameter logic [7:0] SPI_BLOCK_ADDR = 8'hAB,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [7:0]  inAddr,
    input  logic [2:0]  cmdCode,
    input  logic        pktStart,
    input  logic        pktDone,
    input  logic        pktError,
    input  logic        smFull,
    input  logic [15:0] msMemUsed,
    output logic        smOpen,
    output logic        smCommit,
    output logic        smRollback,
    output logic        msOpen,
    output logic        msCommit,
    output logic        msRollback,
    output logic        enablePushFromSpi,
    output logic [1:0]  muxKeyPopToSpi,
    output logic        outEnable,
    output logic        statusEnable,
    output logic [15:0] outDataSize,
    output logic        nResetRequest,
    output logic        busy,
    output logic        timeoutEvt
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RX_DATA   = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_STS    = 3'd3;
    localparam logic [2:0] RESET_REQ = 3'd4;

    localparam logic [2:0] CMD_RESET    = 3'd1;
    localparam logic [2:0] CMD_SEND     = 3'd2;
    localparam logic [2:0] CMD_RECV_STS = 3'd3;
    localparam logic [2:0] CMD_RECV     = 3'd4;

    logic [2:0]  state, nState;
    logic        nSmOpen, nSmCommit, nSmRollback;
    logic        nMsOpen, nMsCommit, nMsRollback;
    logic        nTimeout;
    logic [15:0] nSize;
    logic        inTxn;
    logic        expire;

    assign inTxn = (state == RX_DATA) || (state == TX_DATA) || (state == TX_STS);

`ifdef MILSPI_TXN_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wdCnt;

    assign expire = inTxn && (wdCnt == WD_LAST);

    // Any state change (including back to IDLE) restarts the count for the next entry.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            wdCnt <= 16'd0;
        else if (nState != state)
            wdCnt <= 16'd0;
        else if (inTxn)
            wdCnt <= wdCnt + 16'd1;
    end
`else
    assign expire = 1'b0;
`endif

    // Exit priority inside a transaction: error, then done, then full, then watchdog.
    always_comb begin
        nState      = state;
        nSize       = outDataSize;
        nSmOpen     = 1'b0;
        nSmCommit   = 1'b0;
        nSmRollback = 1'b0;
        nMsOpen     = 1'b0;
        nMsCommit   = 1'b0;
        nMsRollback = 1'b0;
        nTimeout    = 1'b0;
        case (state)
            IDLE: begin
                if (pktStart && (inAddr == SPI_BLOCK_ADDR)) begin
                    case (cmdCode)
                        CMD_SEND: begin
                            nState  = RX_DATA;
                            nSmOpen = 1'b1;
                        end
                        CMD_RECV: begin
                            nState  = TX_DATA;
                            nMsOpen = 1'b1;
                            nSize   = msMemUsed;
                        end
                        CMD_RECV_STS: begin
                            nState = TX_STS;
                            nSize  = 16'd2;
                        end
                        CMD_RESET: nState = RESET_REQ;
                        default:   nState = IDLE;
                    endcase
                end
            end
            RX_DATA: begin
                if (pktError || (!pktDone && smFull) || (!pktDone && expire)) begin
                    nState      = IDLE;
                    nSmRollback = 1'b1;
                    nTimeout    = !pktError && !smFull;
                end else if (pktDone) begin
                    nState    = IDLE;
                    nSmCommit = 1'b1;
                end
            end
            TX_DATA: begin
                if (pktError || (!pktDone && expire)) begin
                    nState      = IDLE;
                    nMsRollback = 1'b1;
                    nTimeout    = !pktError;
                end else if (pktDone) begin
                    nState    = IDLE;
                    nMsCommit = 1'b1;
                end
            end
            TX_STS: begin
                if (pktError || pktDone || expire) begin
                    nState   = IDLE;
                    nTimeout = !pktError && !pktDone;
                end
            end
            RESET_REQ: nState = RESET_REQ;
            default:   nState = IDLE;
        endcase
    end

    // Selects are decoded from the next state so they move on the same edge as the pulses.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state             <= IDLE;
            smOpen            <= 1'b0;
            smCommit          <= 1'b0;
            smRollback        <= 1'b0;
            msOpen            <= 1'b0;
            msCommit          <= 1'b0;
            msRollback        <= 1'b0;
            enablePushFromSpi <= 1'b0;
            muxKeyPopToSpi    <= 2'd0;
            outEnable         <= 1'b0;
            statusEnable      <= 1'b0;
            outDataSize       <= 16'd0;
            nResetRequest     <= 1'b1;
            busy              <= 1'b0;
            timeoutEvt        <= 1'b0;
        end else begin
            state             <= nState;
            smOpen            <= nSmOpen;
            smCommit          <= nSmCommit;
            smRollback        <= nSmRollback;
            msOpen            <= nMsOpen;
            msCommit          <= nMsCommit;
            msRollback        <= nMsRollback;
            enablePushFromSpi <= (nState == RX_DATA);
            muxKeyPopToSpi    <= (nState == TX_STS) ? 2'd1 : 2'd0;
            outEnable         <= (nState == TX_DATA) || (nState == TX_STS);
            statusEnable      <= (nState == TX_STS);
            outDataSize       <= nSize;
            nResetRequest     <= (nState != RESET_REQ);
            busy              <= (nState != IDLE);
            timeoutEvt        <= nTimeout;
        end
    end

endmodule

// File: tb/tb_milspi_txn_ctrl.sv
// Self-checking bench for milspi_txn_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_milspi_txn_ctrl;

    localparam int         TMO  = 16;
    localparam logic [7:0] ADDR = 8'hAB;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [7:0]  inAddr = 8'd0;
    logic [2:0]  cmdCode = 3'd0;
    logic        pktStart = 1'b0, pktDone = 1'b0, pktError = 1'b0, smFull = 1'b0;
    logic [15:0] msMemUsed = 16'd0;
    logic        smOpen, smCommit, smRollback, msOpen, msCommit, msRollback;
    logic        enablePushFromSpi, outEnable, statusEnable, nResetRequest, busy, timeoutEvt;
    logic [1:0]  muxKeyPopToSpi;
    logic [15:0] outDataSize;

    always #5 clk = ~clk;

    milspi_txn_ctrl #(.SPI_BLOCK_ADDR(ADDR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .nRst(nRst), .inAddr(inAddr), .cmdCode(cmdCode),
        .pktStart(pktStart), .pktDone(pktDone), .pktError(pktError),
        .smFull(smFull), .msMemUsed(msMemUsed),
        .smOpen(smOpen), .smCommit(smCommit), .smRollback(smRollback),
        .msOpen(msOpen), .msCommit(msCommit), .msRollback(msRollback),
        .enablePushFromSpi(enablePushFromSpi), .muxKeyPopToSpi(muxKeyPopToSpi),
        .outEnable(outEnable), .statusEnable(statusEnable), .outDataSize(outDataSize),
        .nResetRequest(nResetRequest), .busy(busy), .timeoutEvt(timeoutEvt)
    );

`ifdef MILSPI_TXN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    int nTests = 0;
    int nFail  = 0;

    // Model: transaction kind 0 none, 1 receive-into-SM, 2 send-from-MS, 3 status, 4 reset pending.
    int          mKind;
    int          mEdge;
    int          mEntry;
    logic [15:0] mSize;
    logic [5:0]  mPulse;   // {smOpen, smCommit, smRollback, msOpen, msCommit, msRollback}
    logic        mTmo;

    function automatic logic [29:0] expVec();
        logic [1:0] key;
        key = (mKind == 3) ? 2'd1 : 2'd0;
        return {mPulse, mKind == 1, key, (mKind == 2) || (mKind == 3), mKind == 3,
                mSize, mKind != 4, mKind != 0, mTmo};
    endfunction

    function automatic logic [29:0] dutVec();
        return {smOpen, smCommit, smRollback, msOpen, msCommit, msRollback, enablePushFromSpi,
                muxKeyPopToSpi, outEnable, statusEnable, outDataSize, nResetRequest, busy, timeoutEvt};
    endfunction

    task automatic modelReset();
        mKind  = 0;
        mSize  = 16'd0;
        mPulse = 6'd0;
        mTmo   = 1'b0;
    endtask

    task automatic modelStep();
        bit expired;
        if (!nRst) begin
            modelReset();
            return;
        end
        mEdge++;
        mPulse  = 6'd0;
        mTmo    = 1'b0;
        expired = TMO_EN && (mKind >= 1) && (mKind <= 3) && (mEdge - mEntry == TMO);
        if (mKind == 0) begin
            if (pktStart && inAddr == ADDR) begin
                mEntry = mEdge;
                if (cmdCode == 3'd2) begin mKind = 1; mPulse[5] = 1'b1; end
                else if (cmdCode == 3'd4) begin mKind = 2; mPulse[2] = 1'b1; mSize = msMemUsed; end
                else if (cmdCode == 3'd3) begin mKind = 3; mSize = 16'd2; end
                else if (cmdCode == 3'd1) mKind = 4;
            end
        end else if (mKind != 4) begin
            if (pktError) begin
                if (mKind == 1) mPulse[3] = 1'b1;
                if (mKind == 2) mPulse[0] = 1'b1;
                mKind = 0;
            end else if (pktDone) begin
                if (mKind == 1) mPulse[4] = 1'b1;
                if (mKind == 2) mPulse[1] = 1'b1;
                mKind = 0;
            end else if (mKind == 1 && smFull) begin
                mPulse[3] = 1'b1;
                mKind = 0;
            end else if (expired) begin
                if (mKind == 1) mPulse[3] = 1'b1;
                if (mKind == 2) mPulse[0] = 1'b1;
                mTmo  = 1'b1;
                mKind = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        nTests++;
        if (dutVec() !== expVec()) begin
            nFail++;
            $display("FAIL outputs t=%0t dut=%h model=%h", $time, dutVec(), expVec());
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic [7:0] a, input logic [2:0] c,
                       input logic d, input logic e, input logic f);
        pktStart = st; inAddr = a; cmdCode = c; pktDone = d; pktError = e; smFull = f;
        @(posedge clk);
        modelStep();
        #1;
        pktStart = 1'b0; pktDone = 1'b0; pktError = 1'b0; smFull = 1'b0;
    endtask

    task automatic idle(); cyc(1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0); endtask

    task automatic pulseReset();
        nRst = 1'b0;
        modelReset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {smOpen, smCommit, smRollback, msOpen, msCommit, msRollback}, 0);
        chk("rst_nResetRequest", nResetRequest, 1);
        idle();
        nRst = 1'b1;
    endtask

    initial begin
        int pushCnt, tmoAt;
        mEdge = 0; mEntry = 0;
        modelReset();
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_size", outDataSize, 0);
        nRst = 1'b1;
        idle();

        // SEND_DATA, pktDone 10 cycles later
        cyc(1'b1, ADDR, 3'd2, 1'b0, 1'b0, 1'b0);
        chk("smOpen", smOpen, 1);
        pushCnt = int'(enablePushFromSpi);
        for (int i = 0; i < 9; i++) begin idle(); pushCnt += int'(enablePushFromSpi); end
        cyc(1'b0, 8'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("smCommit", smCommit, 1);
        chk("push_cycles", pushCnt, 10);
        chk("busy_after_commit", busy, 0);
        idle();

        // RECEIVE_DATA with 37 words, then error
        msMemUsed = 16'd37;
        cyc(1'b1, ADDR, 3'd4, 1'b0, 1'b0, 1'b0);
        msMemUsed = 16'd5;
        chk("msOpen", msOpen, 1);
        chk("outDataSize_37", outDataSize, 37);
        chk("outEnable_tx", outEnable, 1);
        chk("muxKey_tx", muxKeyPopToSpi, 0);
        idle(); idle();
        cyc(1'b0, 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("msRollback", msRollback, 1);
        chk("msCommit_none", msCommit, 0);

        // RECEIVE_STS foreign then own address
        cyc(1'b1, 8'h12, 3'd3, 1'b0, 1'b0, 1'b0);
        chk("foreign_busy", busy, 0);
        cyc(1'b1, ADDR, 3'd3, 1'b0, 1'b0, 1'b0);
        chk("sts_muxKey", muxKeyPopToSpi, 1);
        chk("sts_enable", statusEnable, 1);
        chk("sts_size", outDataSize, 2);
        cyc(1'b0, 8'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("sts_done_busy", busy, 0);

        // watchdog
        cyc(1'b1, ADDR, 3'd2, 1'b0, 1'b0, 1'b0);
        tmoAt = 0;
        for (int k = 1; k <= 20; k++) begin
            idle();
            if (timeoutEvt && tmoAt == 0) begin
                tmoAt = k;
                chk("tmo_rollback", smRollback, 1);
            end
        end
`ifdef MILSPI_TXN_TIMEOUT_EN
        chk("tmo_cycle", tmoAt, TMO);
        chk("tmo_busy", busy, 0);
`else
        chk("no_tmo_cycle", tmoAt, 0);
        chk("no_tmo_busy", busy, 1);
`endif
        cyc(1'b0, 8'd0, 3'd0, 1'b1, 1'b0, 1'b0);

        // done+error collision, then a second start while busy
        cyc(1'b1, ADDR, 3'd2, 1'b0, 1'b0, 1'b0);
        idle();
        cyc(1'b0, 8'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        chk("collide_rollback", smRollback, 1);
        chk("collide_commit", smCommit, 0);
        cyc(1'b1, ADDR, 3'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, ADDR, 3'd4, 1'b0, 1'b0, 1'b0);
        chk("busy_start_msOpen", msOpen, 0);
        chk("busy_start_push", enablePushFromSpi, 1);
        cyc(1'b0, 8'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("full_done_commit", smCommit, 1);

        // RESET command holds request until nRst
        cyc(1'b1, ADDR, 3'd1, 1'b0, 1'b0, 1'b0);
        chk("nResetRequest_low", nResetRequest, 0);
        cyc(1'b1, ADDR, 3'd2, 1'b1, 1'b1, 1'b0);
        idle();
        chk("nResetRequest_held", nResetRequest, 0);
        pulseReset();

        // reset mid-RX_DATA
        cyc(1'b1, ADDR, 3'd2, 1'b0, 1'b0, 1'b0);
        idle(); idle();
        pulseReset();
        idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ADDR;
            msMemUsed = 16'($urandom);
            cyc($urandom_range(0, 3) == 0, a, 3'($urandom), $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0);
            if ((mKind == 4 && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
                pulseReset();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
